collision_detector: RTL and testbench



---
 rtl/collision_pkg.sv | 8 +
 rtl/frame_sticky_flag.sv | 27 ++
 rtl/collision_detector.sv | 125 ++++++++++++
 tb/tb_collision_detector.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and constants for the collision detector slice.
package collision_pkg;

   typedef enum logic {PS_ARMED = 1'b0, PS_COOLDOWN = 1'b1} player_state_t;

   localparam int COORD_W = 11;

endpackage

// File: rtl/frame_sticky_flag.sv
// Per-frame sticky flag: accumulates a condition over a frame and publishes it
// as a one-cycle pulse the cycle after startOfFrame.
module frame_sticky_flag (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic cond,
   output logic pulse
);

   logic flag;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         flag  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         pulse <= startOfFrame & flag;
         // A condition seen on the boundary cycle belongs to the new frame.
         if (startOfFrame)
            flag <= cond;
         else if (cond)
            flag <= 1'b1;
      end
   end

endmodule

// File: rtl/collision_detector.sv
// Frame-accumulated collision detection with player invulnerability cooldown.
// Optional macro COLLISION_HIT_POS_EN reports the first missile/alien overlap pixel.
module collision_detector
   import collision_pkg::*;
#(
   parameter int INVULN_FRAMES = 60,
   parameter int CNT_W         = 7
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic [COORD_W-1:0] pixelX,
   input  logic [COORD_W-1:0] pixelY,
   input  logic               missleDR,
   input  logic               alienDR,
   input  logic               playerDR,
   input  logic               enemyMissileDR,
   output logic               missileHit,
   output logic               playerHit,
   output logic               playerInvulnerable,
   output logic [COORD_W-1:0] hitX,
   output logic [COORD_W-1:0] hitY
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic m_hit_c;
   logic p_hit_c;
   logic p_pulse;
   logic sof_d;

   player_state_t    state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   assign m_hit_c = missleDR & alienDR;
   assign p_hit_c = playerDR & (enemyMissileDR | alienDR);

   frame_sticky_flag u_missile_flag (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .cond         (m_hit_c),
      .pulse        (missileHit)
   );

   frame_sticky_flag u_player_flag (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .cond         (p_hit_c),
      .pulse        (p_pulse)
   );

   // The FSM acts one cycle after the boundary, when the flag snapshot is visible.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state              <= PS_ARMED;
         cnt                <= '0;
         sof_d              <= 1'b0;
         playerInvulnerable <= 1'b0;
      end else begin
         state              <= state_nxt;
         cnt                <= cnt_nxt;
         sof_d              <= startOfFrame;
         playerInvulnerable <= (state_nxt == PS_COOLDOWN);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (sof_d) begin
         if (state == PS_ARMED) begin
            if (p_pulse && (INVULN_FRAMES > 0)) begin
               state_nxt = PS_COOLDOWN;
               cnt_nxt   = CNT_LOAD;
            end
         end else begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE)
               state_nxt = PS_ARMED;
         end
      end
   end

   always_comb begin
      playerHit = p_pulse & (state == PS_ARMED);
   end

`ifdef COLLISION_HIT_POS_EN
   logic               seen;
   logic               first_hit;
   logic [COORD_W-1:0] lat_x, lat_y;

   assign first_hit = m_hit_c & (startOfFrame | ~seen);

   // The latch is read before it is overwritten, so a boundary-cycle hit starts the new frame.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         seen  <= 1'b0;
         lat_x <= '0;
         lat_y <= '0;
         hitX  <= '0;
         hitY  <= '0;
      end else begin
         seen <= startOfFrame ? m_hit_c : (seen | m_hit_c);
         if (first_hit) begin
            lat_x <= pixelX;
            lat_y <= pixelY;
         end
         if (startOfFrame && seen) begin
            hitX <= lat_x;
            hitY <= lat_y;
         end
      end
   end
`else
   logic unused_pix;
   assign unused_pix = ^{pixelX, pixelY};
   assign hitX = '0;
   assign hitY = '0;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed table, hand sequences and
// randomized traffic against a frame-level reference model.
module tb_collision_detector;

   localparam int INV_A = 3;
   localparam int INV_B = 0;
`ifdef COLLISION_HIT_POS_EN
   localparam bit POS_EN = 1'b1;
`else
   localparam bit POS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        sof = 1'b0;
   logic [10:0] px = '0, py = '0;
   logic        mdr = 1'b0, adr = 1'b0, pdr = 1'b0, edr = 1'b0;
   logic        mhit_a, phit_a, inv_a, mhit_b, phit_b, inv_b;
   logic [10:0] hx_a, hy_a, hx_b, hy_b;

   int checks = 0;
   int failures = 0;
   int pa_cnt = 0;

   always #5 clk = ~clk;

   collision_detector #(.INVULN_FRAMES(INV_A), .CNT_W(7)) dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
      .missleDR(mdr), .alienDR(adr), .playerDR(pdr), .enemyMissileDR(edr),
      .missileHit(mhit_a), .playerHit(phit_a), .playerInvulnerable(inv_a),
      .hitX(hx_a), .hitY(hy_a)
   );

   collision_detector #(.INVULN_FRAMES(INV_B), .CNT_W(7)) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
      .missleDR(mdr), .alienDR(adr), .playerDR(pdr), .enemyMissileDR(edr),
      .missileHit(mhit_b), .playerHit(phit_b), .playerInvulnerable(inv_b),
      .hitX(hx_b), .hitY(hy_b)
   );

   // Frame-level reference model
   bit          m_acc, p_acc;
   logic [10:0] fx, fy;
   int          cd_a, cd_b;
   bit          pend_a, pend_b;
   bit          e_m, e_pa, e_pb, e_ia, e_ib;
   logic [10:0] e_hx, e_hy;

   task automatic model_reset();
      m_acc = 0; p_acc = 0; fx = '0; fy = '0;
      cd_a = 0; cd_b = 0; pend_a = 0; pend_b = 0;
      e_m = 0; e_pa = 0; e_pb = 0; e_ia = 0; e_ib = 0;
      e_hx = '0; e_hy = '0;
   endtask

   task automatic model_edge(input bit s, m, a, p, e, input logic [10:0] x, y);
      bit mh, ph;
      mh = m & a;
      ph = p & (e | a);
      e_ia = pend_a;
      e_ib = pend_b;
      if (s) begin
         e_m = m_acc;
         if (m_acc && POS_EN) begin e_hx = fx; e_hy = fy; end
         if (cd_a == 0) begin
            e_pa = p_acc;
            if (p_acc && INV_A > 0) cd_a = INV_A;
         end else begin
            e_pa = 0; cd_a = cd_a - 1;
         end
         if (cd_b == 0) begin
            e_pb = p_acc;
            if (p_acc && INV_B > 0) cd_b = INV_B;
         end else begin
            e_pb = 0; cd_b = cd_b - 1;
         end
         pend_a = (cd_a > 0);
         pend_b = (cd_b > 0);
         m_acc = mh;
         p_acc = ph;
         if (mh) begin fx = x; fy = y; end
      end else begin
         e_m = 0; e_pa = 0; e_pb = 0;
         if (mh && !m_acc) begin fx = x; fy = y; end
         m_acc = m_acc | mh;
         p_acc = p_acc | ph;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("missileHit_a", 32'(mhit_a), 32'(e_m));
      chk("missileHit_b", 32'(mhit_b), 32'(e_m));
      chk("playerHit_a", 32'(phit_a), 32'(e_pa));
      chk("playerHit_b", 32'(phit_b), 32'(e_pb));
      chk("invuln_a", 32'(inv_a), 32'(e_ia));
      chk("invuln_b", 32'(inv_b), 32'(e_ib));
      chk("hitX_a", 32'(hx_a), 32'(e_hx));
      chk("hitY_a", 32'(hy_a), 32'(e_hy));
      chk("hitX_b", 32'(hx_b), 32'(e_hx));
      chk("hitY_b", 32'(hy_b), 32'(e_hy));
   endtask

   task automatic step(input bit s, m, a, p, e, input logic [10:0] x, y);
      @(negedge clk);
      sof = s; mdr = m; adr = a; pdr = p; edr = e; px = x; py = y;
      @(posedge clk);
      model_edge(s, m, a, p, e, x, y);
      #1;
      if (phit_a) pa_cnt++;
      compare_all();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetN = 0;
      sof = 0; mdr = 0; adr = 0; pdr = 0; edr = 0;
      #1;
      model_reset();
      compare_all();
      repeat (2) @(negedge clk);
      resetN = 1;
   endtask

   typedef struct {
      bit          s, m, a, p, e;
      logic [10:0] x, y;
      bit          em, ep, ei;
      logic [10:0] ehx, ehy;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input bit s, m, a, p, e, input int x, y,
                               input bit em, ep, ei, input int ehx, ehy);
      vec_t v;
      v.s = s; v.m = m; v.a = a; v.p = p; v.e = e;
      v.x = 11'(x); v.y = 11'(y);
      v.em = em; v.ep = ep; v.ei = ei;
      v.ehx = 11'(ehx); v.ehy = 11'(ehy);
      return v;
   endfunction

   initial begin
      logic [10:0] tx, ty;
      model_reset();
      // Missile overlap for 3 cycles, quiet frame, boundary-only overlap, then a joint hit.
      tbl[0]  = mk(1,0,0,0,0,   0,  0, 0,0,0,   0,  0);
      tbl[1]  = mk(0,0,0,0,0,   0,  0, 0,0,0,   0,  0);
      tbl[2]  = mk(0,1,1,0,0, 100,200, 0,0,0,   0,  0);
      tbl[3]  = mk(0,1,1,0,0, 101,201, 0,0,0,   0,  0);
      tbl[4]  = mk(0,1,1,0,0, 102,202, 0,0,0,   0,  0);
      tbl[5]  = mk(0,0,0,0,0,   0,  0, 0,0,0,   0,  0);
      tbl[6]  = mk(1,0,0,0,0,   0,  0, 1,0,0, 100,200);
      tbl[7]  = mk(0,0,0,0,0,   0,  0, 0,0,0, 100,200);
      tbl[8]  = mk(1,0,0,0,0,   0,  0, 0,0,0, 100,200);
      tbl[9]  = mk(0,0,0,0,0,   0,  0, 0,0,0, 100,200);
      tbl[10] = mk(1,1,1,0,0,   5,  6, 0,0,0, 100,200);
      tbl[11] = mk(0,0,0,0,0,   0,  0, 0,0,0, 100,200);
      tbl[12] = mk(1,0,0,0,0,   0,  0, 1,0,0,   5,  6);
      tbl[13] = mk(0,1,1,1,1,   7,  8, 0,0,0,   5,  6);
      tbl[14] = mk(1,0,0,0,0,   0,  0, 1,1,0,   7,  8);
      tbl[15] = mk(0,0,0,0,0,   0,  0, 0,0,1,   7,  8);

      #1;
      compare_all();
      repeat (2) @(negedge clk);
      resetN = 1;

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].s, tbl[i].m, tbl[i].a, tbl[i].p, tbl[i].e, tbl[i].x, tbl[i].y);
         chk($sformatf("tbl%0d_missileHit", i), 32'(mhit_a), 32'(tbl[i].em));
         chk($sformatf("tbl%0d_playerHit", i), 32'(phit_a), 32'(tbl[i].ep));
         chk($sformatf("tbl%0d_invuln", i), 32'(inv_a), 32'(tbl[i].ei));
         chk($sformatf("tbl%0d_hitX", i), 32'(hx_a), POS_EN ? 32'(tbl[i].ehx) : 32'd0);
         chk($sformatf("tbl%0d_hitY", i), 32'(hy_a), POS_EN ? 32'(tbl[i].ehy) : 32'd0);
      end

      // Cooldown: player overlaps in frames 1-4; only frame 4 should produce a hit.
      pa_cnt = 0;
      for (int f = 0; f < 4; f++) begin
         step(0,0,0,1,1, 0,0);
         step(0,0,0,0,0, 0,0);
         step(1,0,0,0,0, 0,0);
      end
      step(0,0,0,0,0, 0,0);
      chk("cooldown_hit_count", 32'(pa_cnt), 32'd1);
      chk("cooldown_rearmed_invuln", 32'(inv_a), 32'd1);

      // Back-to-back boundaries with overlaps.
      step(0,1,1,1,0, 9,9);
      step(1,0,0,0,0, 0,0);
      step(1,1,1,0,0, 3,4);
      step(0,0,0,0,0, 0,0);

      // Reset mid-frame after overlaps: nothing published afterwards.
      step(0,1,1,1,1, 50,60);
      apply_reset();
      step(1,0,0,0,0, 0,0);
      chk("post_reset_missileHit", 32'(mhit_a), 32'd0);
      chk("post_reset_playerHit", 32'(phit_a), 32'd0);
      step(0,0,0,0,0, 0,0);

      // Randomized traffic, including back-to-back boundaries.
      for (int c = 0; c < 1500; c++) begin
         tx = 11'($urandom_range(0, 2047));
         ty = 11'($urandom_range(0, 2047));
         step($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, tx, ty);
         if (c == 700) apply_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
